push_evt_ctrl: RTL and testbench

- Downstream consumer of the push-button synchroniser/edge-detector stage.
- Takes that stage's single-cycle rising-edge pulse and applies a re-trigger holdoff window so that bounce is not counted.
- Counts accepted presses for the LED display and keeps a queue of pending interrupts; software acknowledges them one at a time.
- Sits between the button front-end and the AXI-facing register/interrupt logic.

---
 rtl/push_evt_pkg.sv | 25 ++
 rtl/push_holdoff_timer.sv | 39 +++
 rtl/push_evt_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_push_evt_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/push_evt_pkg.sv
// ----------------------------------------------------------------------------
// push_evt_pkg
// Shared types and constants for the push-button event controller.
//   state_t     : controller FSM states (IDLE accepting, HOLD window running)
//   TMR_W       : width of the holdoff down-counter
//   DROP_W      : width of the rejected-pulse statistics counter
//   DROP_MAX    : saturation value of that counter
// ----------------------------------------------------------------------------
package push_evt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int TMR_W  = 16;
    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Saturating increment used by the statistics counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/push_holdoff_timer.sv
// ----------------------------------------------------------------------------
// push_holdoff_timer
// Loadable down-counter that times the re-trigger holdoff window.
// Ports:
//   i_clk      : clock
//   i_srst     : synchronous active-high reset, clears the count
//   i_load     : load i_load_val on this edge (has priority over counting)
//   i_load_val : value loaded
//   o_busy     : count is non-zero
//   o_expire   : count is 1, i.e. the next edge brings it to 0; this marks
//                the final cycle of the window
// ----------------------------------------------------------------------------
module push_holdoff_timer
    import push_evt_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_busy,
    output logic             o_expire
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy   = (r_count != '0);
    assign o_expire = (r_count == TMR_W'(1));

endmodule

// File: rtl/push_evt_ctrl.sv
// ----------------------------------------------------------------------------
// push_evt_ctrl
// Accepts single-cycle press pulses from the button edge detector, rejects
// re-triggers inside a holdoff window, counts accepted presses for the LEDs
// and keeps a saturating count of pending interrupts that software retires
// one acknowledge at a time.
//
// Build option: define PUSH_EVT_STATS_EN to enable the rejected-pulse
// counter on drop_cnt; otherwise drop_cnt is constant 0.
//
// Ports:
//   S_AXI_ACLK   : clock
//   S_AXI_ARESET : synchronous active-high reset
//   evt_pulse    : one-cycle press pulse
//   evt_en       : event enable (low rejects every pulse)
//   irq_ack      : one-cycle acknowledge, retires one pending interrupt
//   cnt_clr      : clears led_on (and drop_cnt when stats are built)
//   led_on       : accepted-press count, wraps
//   irq          : high while pending count is non-zero
//   pend_cnt     : saturating pending-interrupt count
//   overflow     : sticky, set on accept while pend_cnt is saturated
//   drop_cnt     : rejected-pulse count, saturating at 255
// ----------------------------------------------------------------------------
module push_evt_ctrl
    import push_evt_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int HOLDOFF_CYC = 16,
    parameter int PEND_W      = 3
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              evt_pulse,
    input  logic              evt_en,
    input  logic              irq_ack,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  led_on,
    output logic              irq,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [TMR_W-1:0]  LOAD_VAL = TMR_W'(HOLDOFF_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    // With a one-cycle window there is nothing to hold off.
    localparam bit USE_HOLD = (HOLDOFF_CYC > 1);

    state_t r_state;
    state_t w_state_next;

    logic w_accept;
    logic w_ack_eff;
    logic w_tmr_busy;
    logic w_tmr_expire;

    logic [CNT_W-1:0]  r_led;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_next;
    logic              r_irq;
    logic              r_ovf;
    logic              w_ovf_set;

    assign w_accept  = evt_pulse & evt_en & (r_state == IDLE);
    // An acknowledge with nothing pending is ignored outright.
    assign w_ack_eff = irq_ack & (r_pend != '0);

    // ------------------------------------------------------------------
    // Holdoff timer
    // ------------------------------------------------------------------
    push_holdoff_timer u_timer (
        .i_clk      (S_AXI_ACLK),
        .i_srst     (S_AXI_ARESET),
        .i_load     (w_accept),
        .i_load_val (LOAD_VAL),
        .o_busy     (w_tmr_busy),
        .o_expire   (w_tmr_expire)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && USE_HOLD) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // Leave on the edge that takes the timer to 0, so the next
                // accept lands exactly HOLDOFF_CYC cycles after the last.
                // The !busy term only guards against a stranded HOLD.
                if (w_tmr_expire || !w_tmr_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Press counter
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_led <= '0;
        end else if (cnt_clr) begin
            r_led <= '0;
        end else if (w_accept) begin
            r_led <= r_led + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending interrupt count / overflow
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pend;
        w_ovf_set   = 1'b0;
        if (w_accept && !w_ack_eff) begin
            if (r_pend == PEND_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_next = r_pend + 1'b1;
            end
        end else if (w_ack_eff && !w_accept) begin
            w_pend_next = r_pend - 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_irq  <= (w_pend_next != '0);
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rejected-pulse statistics
    // ------------------------------------------------------------------
`ifdef PUSH_EVT_STATS_EN
    logic              w_reject;
    logic [DROP_W-1:0] r_drop;

    assign w_reject = evt_pulse & ~w_accept;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_drop <= '0;
        end else if (cnt_clr) begin
            r_drop <= '0;
        end else if (w_reject) begin
            r_drop <= sat_inc(r_drop);
        end
    end

    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

    assign led_on   = r_led;
    assign irq      = r_irq;
    assign pend_cnt = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_push_evt_ctrl.sv
module tb_push_evt_ctrl;

    localparam int CNT_W       = 4;
    localparam int HOLDOFF_CYC = 16;
    localparam int PEND_W      = 3;
    localparam int PEND_MAX    = (1 << PEND_W) - 1;
    localparam int LED_MOD     = (1 << CNT_W);

    logic             clk = 1'b0;
    logic             rst;
    logic             evt_pulse;
    logic             evt_en;
    logic             irq_ack;
    logic             cnt_clr;
    logic [CNT_W-1:0] led_on;
    logic             irq;
    logic [PEND_W-1:0] pend_cnt;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: acceptance decided purely from the time since the
    // last accepted press.
    int cyc      = 0;
    int last_acc = 0;
    bit have_acc = 0;
    int m_led    = 0;
    int m_pend   = 0;
    int m_ovf    = 0;
    int m_drop   = 0;

    always #5 clk = ~clk;

    push_evt_ctrl #(
        .CNT_W       (CNT_W),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .PEND_W      (PEND_W)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .evt_pulse    (evt_pulse),
        .evt_en       (evt_en),
        .irq_ack      (irq_ack),
        .cnt_clr      (cnt_clr),
        .led_on       (led_on),
        .irq          (irq),
        .pend_cnt     (pend_cnt),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit p, input bit en, input bit ack,
                        input bit clr, input bit r);
        bit acc;
        bit ack_eff;
        rst       = r;
        evt_pulse = p;
        evt_en    = en;
        irq_ack   = ack;
        cnt_clr   = clr;
        if (r) begin
            have_acc = 0;
            m_led = 0; m_pend = 0; m_ovf = 0; m_drop = 0;
        end else begin
            acc = p && en && (!have_acc || (cyc - last_acc) >= HOLDOFF_CYC);
            if (acc) begin
                have_acc = 1;
                last_acc = cyc;
            end
            ack_eff = ack && (m_pend > 0);
            if (clr)      m_led = 0;
            else if (acc) m_led = (m_led + 1) % LED_MOD;
            if (acc && !ack_eff) begin
                if (m_pend == PEND_MAX) m_ovf = 1;
                else                    m_pend++;
            end else if (ack_eff && !acc) begin
                m_pend--;
            end
            if (clr)                      m_drop = 0;
            else if (p && !acc && m_drop < 255) m_drop++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("led_on",   int'(led_on),   m_led);
        check("pend_cnt", int'(pend_cnt), m_pend);
        check("irq",      int'(irq),      (m_pend != 0) ? 1 : 0);
        check("overflow", int'(overflow), m_ovf);
`ifdef PUSH_EVT_STATS_EN
        check("drop_cnt", int'(drop_cnt), m_drop);
`else
        check("drop_cnt", int'(drop_cnt), 0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; evt_pulse = 0; evt_en = 0; irq_ack = 0; cnt_clr = 0;

        // Reset with a pulse present: nothing counted.
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        $display("phase reset: led=%0d pend=%0d irq=%0d", led_on, pend_cnt, irq);
        step(1, 1, 0, 0, 0);
        idle(HOLDOFF_CYC);
        check("reset_first_led", int'(led_on), 1);

        // Holdoff: pulses at 0, 5 and 16.
        step(1, 1, 1, 0, 0);       // accept + ack of the earlier event
        idle(4);
        step(1, 1, 0, 0, 0);       // cycle 5, rejected
        idle(10);
        step(1, 1, 0, 0, 0);       // cycle 16, accepted
        $display("phase holdoff: led=%0d pend=%0d drop=%0d", led_on, pend_cnt, drop_cnt);
        check("holdoff_pend", int'(pend_cnt), 2);

        // Wrap: 17 more spaced accepts, then clear coinciding with a pulse.
        for (int i = 0; i < 17; i++) begin
            idle(HOLDOFF_CYC - 1);
            step(1, 1, (i % 2), 0, 0);
        end
        idle(HOLDOFF_CYC - 1);
        step(1, 1, 0, 1, 0);
        $display("phase wrap/clear: led=%0d pend=%0d ovf=%0d", led_on, pend_cnt, overflow);
        check("clr_led", int'(led_on), 0);

        // Saturation then drain.
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            idle(HOLDOFF_CYC - 1);
            step(1, 1, 0, 0, 0);
        end
        check("sat_pend", int'(pend_cnt), 7);
        check("sat_ovf", int'(overflow), 1);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);       // ack at zero ignored
        $display("phase saturate: pend=%0d irq=%0d ovf=%0d", pend_cnt, irq, overflow);

        // Simultaneous accept + ack at pend=3 and at pend=7.
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle(HOLDOFF_CYC - 1);
            step(1, 1, 0, 0, 0);
        end
        idle(HOLDOFF_CYC - 1);
        step(1, 1, 1, 0, 0);
        check("simul3_pend", int'(pend_cnt), 3);
        for (int i = 0; i < 4; i++) begin
            idle(HOLDOFF_CYC - 1);
            step(1, 1, 0, 0, 0);
        end
        idle(HOLDOFF_CYC - 1);
        step(1, 1, 1, 0, 0);
        check("simul7_ovf", int'(overflow), 0);
        $display("phase simultaneous: pend=%0d ovf=%0d", pend_cnt, overflow);

        // Mid-window reset (timer around 8) then an immediate pulse.
        idle(HOLDOFF_CYC);
        step(1, 1, 0, 0, 0);
        idle(7);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        check("midreset_led", int'(led_on), 1);
        $display("phase mid-reset: led=%0d pend=%0d", led_on, pend_cnt);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 499) == 0));
        end
        $display("phase random: cycles=%0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
